// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one single-port memory between instruction fetch and load/store,
// one transaction outstanding, with store lane steering and load extension.
module mem_access_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_rdata,
    output logic        if_error,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_resp_valid,
    output logic [31:0] d_rdata,
    output logic        d_error,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t      state_q, state_d;
    logic        last_q, last_d, own_q, own_d, we_q, we_d, err_q, err_d;
    logic [2:0]  f3_q, f3_d, cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic        idle, issue, resp, pick_d, acc, mis, d_bad, a_err;
    logic [31:0] shifted, ext;
    logic [15:0] half_sel;
    assign idle  = state_q == IDLE;
    assign issue = state_q == ISSUE;
    assign resp  = state_q == RESP;
    // last_q = 1 means data was granted last, so fetch wins the next tie
    assign pick_d = d_req_valid && (!if_req_valid || !last_q);
    assign acc    = idle && (if_req_valid || d_req_valid);
    assign if_req_ready = idle && !pick_d;
    assign d_req_ready  = idle && !(if_req_valid && !pick_d);
    assign mis   = (d_funct3[1:0] == 2'b01 && d_addr[0]) || (d_funct3[1:0] == 2'b10 && d_addr[1:0] != 2'b00);
    assign d_bad = mis || (d_we ? (d_funct3[2] || d_funct3[1:0] == 2'b11)
                                : (d_funct3 == 3'b011 || d_funct3[2:1] == 2'b11));
    assign a_err = pick_d ? d_bad : if_addr[1:0] != 2'b00;
    assign shifted  = mem_rdata >> {addr_q[1:0], 3'b000};
    assign half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign ext = !own_q || f3_q[1] ? mem_rdata :
                 f3_q[0] ? {{16{!f3_q[2] && half_sel[15]}}, half_sel} :
                           {{24{!f3_q[2] && shifted[7]}}, shifted[7:0]};
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        own_d   = own_q;
        we_d    = we_q;
        err_d   = err_q;
        f3_d    = f3_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: if (acc) begin
                own_d   = pick_d;
                last_d  = pick_d;
                we_d    = pick_d && d_we;
                f3_d    = d_funct3;
                addr_d  = pick_d ? d_addr : if_addr;
                wdata_d = d_wdata;
                err_d   = a_err;
                rdata_d = '0;
                state_d = a_err ? RESP : ISSUE;
            end
            ISSUE: begin
                cnt_d   = 3'd1;
                state_d = we_q ? RESP : WAIT;
            end
            WAIT: if (cnt_q == 3'(READ_LATENCY)) begin
                rdata_d = ext;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            own_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            own_q   <= own_d;
            we_q    <= we_d;
            err_q   <= err_d;
            f3_q    <= f3_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
    assign mem_en    = issue;
    assign mem_we    = issue && we_q;
    assign mem_addr  = issue ? {addr_q[31:2], 2'b00} : '0;
    assign mem_be    = !issue ? 4'b0000 : !we_q ? 4'b1111 :
                       f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                       f3_q[1:0] == 2'b01 ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
    assign mem_wdata = !mem_we ? '0 :
                       f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                       f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    assign if_resp_valid = resp && !own_q;
    assign d_resp_valid  = resp && own_q;
    assign if_rdata = if_resp_valid ? rdata_q : '0;
    assign d_rdata  = d_resp_valid ? rdata_q : '0;
    assign if_error = if_resp_valid && err_q;
    assign d_error  = d_resp_valid && err_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: drives an L=1 and an L=4 arbiter with shared requests and
// checks each against a rule-level model of the memory access behaviour.
module tb_mem_access_arbiter;
    logic clk = 0, reset = 1;
    logic if_req_valid = 0, d_req_valid = 0, d_we = 0;
    logic [2:0]  d_funct3 = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
    logic        if_rdy [2], d_rdy [2], if_rv [2], d_rv [2], if_err [2], d_err [2], m_en [2], m_we [2];
    logic [31:0] if_rd [2], d_rd [2], m_addr [2], m_wd [2], m_rd [2], rd_q [2];
    logic [3:0]  m_be [2];
    logic [31:0] mem [1024];
    int cyc = 0, t0 = 0, g_lo = 1, g_hi = 0;
    int checks = 0, errors = 0;
    int o_en, o_en_cyc, o_resp, o_who_d, o_other, o_rdy, o_rdy_rst;
    logic o_acc, o_err, o_we;
    logic [31:0] o_data, o_addr, o_wd;
    logic [3:0]  o_be;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // memory: latches the addressed word on a read strobe and holds it
    always @(posedge clk) begin
        if (m_en[0] && !m_we[0]) rd_q[0] <= mem[m_addr[0][11:2]];
        if (m_en[1] && !m_we[1]) rd_q[1] <= mem[m_addr[1][11:2]];
    end
    assign m_rd[0] = (cyc - t0 >= g_lo && cyc - t0 <= g_hi) ? 32'hDEAD_BEEF ^ cyc : rd_q[0];
    assign m_rd[1] = (cyc - t0 >= g_lo && cyc - t0 <= g_hi) ? 32'hBAD0_0BAD ^ cyc : rd_q[1];

    mem_access_arbiter #(.READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_rdy[0]), .if_addr(if_addr),
        .if_resp_valid(if_rv[0]), .if_rdata(if_rd[0]), .if_error(if_err[0]),
        .d_req_valid(d_req_valid), .d_req_ready(d_rdy[0]), .d_we(d_we), .d_funct3(d_funct3),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_resp_valid(d_rv[0]), .d_rdata(d_rd[0]), .d_error(d_err[0]),
        .mem_en(m_en[0]), .mem_we(m_we[0]), .mem_be(m_be[0]), .mem_addr(m_addr[0]),
        .mem_wdata(m_wd[0]), .mem_rdata(m_rd[0]));
    mem_access_arbiter #(.READ_LATENCY(4)) dut4 (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_rdy[1]), .if_addr(if_addr),
        .if_resp_valid(if_rv[1]), .if_rdata(if_rd[1]), .if_error(if_err[1]),
        .d_req_valid(d_req_valid), .d_req_ready(d_rdy[1]), .d_we(d_we), .d_funct3(d_funct3),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_resp_valid(d_rv[1]), .d_rdata(d_rd[1]), .d_error(d_err[1]),
        .mem_en(m_en[1]), .mem_we(m_we[1]), .mem_be(m_be[1]), .mem_addr(m_addr[1]),
        .mem_wdata(m_wd[1]), .mem_rdata(m_rd[1]));

    function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] b, h;
        b = (w >> (a[1:0] * 5'd8)) & 32'h0000_00FF;
        h = (w >> (a[1] ? 16 : 0)) & 32'h0000_FFFF;
        case (f3)
            3'd0: return b >= 32'd128 ? b - 32'd256 : b;
            3'd1: return h >= 32'd32768 ? h - 32'd65536 : h;
            3'd4: return b;
            3'd5: return h;
            default: return w;
        endcase
    endfunction

    function automatic bit err_model(input bit dat, input bit we, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        if (!dat) return a[1:0] != 2'b00;
        if (we ? f3 > 3'd2 : (f3 == 3'd3 || f3 > 3'd5)) return 1'b1;
        sz = 1 << f3[1:0];
        return (int'(a[1:0]) % sz) != 0;
    endfunction

    task automatic reset_dut();
        if_req_valid = 0; d_req_valid = 0; reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    // one request from a single requester; records what the chosen instance does
    task automatic run(input int k, input bit dat, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int rst_at);
        @(posedge clk); #1;
        t0 = cyc;
        if_req_valid = !dat; if_addr = a;
        d_req_valid = dat; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
        @(negedge clk);
        o_acc = dat ? d_rdy[k] : if_rdy[k];
        @(posedge clk); #1;
        if_req_valid = 0; d_req_valid = 0;
        if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_funct3 = 3'($urandom); d_we = 1'($urandom);
        o_en = 0; o_en_cyc = -1; o_resp = -1; o_who_d = 0; o_other = 0; o_rdy_rst = 0;
        o_be = 0; o_addr = 0; o_wd = 0; o_we = 0; o_data = 0; o_err = 0;
        for (int c = 1; c <= 12 && o_resp < 0; c++) begin
            @(negedge clk);
            if (m_en[k]) begin
                o_en++; o_en_cyc = c; o_be = m_be[k]; o_addr = m_addr[k]; o_wd = m_wd[k]; o_we = m_we[k];
            end
            if (if_rv[k] || d_rv[k]) begin
                o_resp = c; o_who_d = int'(d_rv[k]);
                o_data = d_rv[k] ? d_rd[k] : if_rd[k];
                o_err  = d_rv[k] ? d_err[k] : if_err[k];
                o_other = d_rv[k] ? int'(if_rv[k] || if_err[k] || |if_rd[k]) : int'(d_err[k] || |d_rd[k]);
            end
            if (c == rst_at + 1) begin
                o_rdy_rst = int'(if_rdy[k] && d_rdy[k]);
                reset = 0;
            end
            if (c == rst_at) reset = 1;
        end
        @(negedge clk);
        o_rdy = int'(dat ? d_rdy[k] : if_rdy[k]);
    endtask

    task automatic test_reset();
        logic [13:0] got;
        reset_dut();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            got = {if_rdy[k], d_rdy[k], if_rv[k], d_rv[k], if_err[k], d_err[k], m_en[k], m_we[k],
                   |m_be[k], |if_rd[k], |d_rd[k], |m_addr[k], |m_wd[k], 1'b0};
            checks++;
            if (got !== 14'b11_0000_0000_0000) begin
                errors++; $display("FAIL reset_outputs k=%0d: got %b expected %b", k, got, 14'b11_0000_0000_0000);
            end
        end
    endtask

    task automatic test_fetch();
        reset_dut();
        run(0, 0, 0, 3'd0, 32'h100, 0, -10);
        checks++;
        if ({o_acc, o_en, o_en_cyc, o_addr} !== {1'b1, 32'd1, 32'd1, 32'h100}) begin
            errors++; $display("FAIL fetch_issue: acc=%0b en=%0d cyc=%0d addr=%h, expected 1 1 1 100", o_acc, o_en, o_en_cyc, o_addr);
        end
        checks++;
        if ({o_resp, o_who_d, o_data, o_err} !== {32'd3, 32'd0, 32'h0050_0093, 1'b0}) begin
            errors++; $display("FAIL fetch_resp: cyc=%0d who_d=%0d data=%h err=%0b, expected 3 0 00500093 0", o_resp, o_who_d, o_data, o_err);
        end
        checks++;
        if (o_rdy !== 1) begin
            errors++; $display("FAIL fetch_ready_again: got %0d expected 1", o_rdy);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        logic [31:0] as  [5] = '{32'h200, 32'h203, 32'h202, 32'h200, 32'h200};
        logic [31:0] exs [5] = '{32'hFFFF_FF81, 32'h0000_0080, 32'hFFFF_80F0, 32'h0000_7F81, 32'h80F0_7F81};
        for (int i = 0; i < 5; i++) begin
            run(0, 1, 0, f3s[i], as[i], 0, -10);
            checks++;
            if ({o_resp, o_who_d, o_data, o_err, o_other} !== {32'd3, 32'd1, exs[i], 1'b0, 32'd0}) begin
                errors++; $display("FAIL load_%0d: cyc=%0d who_d=%0d data=%h err=%0b other=%0d, expected 3 1 %h 0 0",
                                   i, o_resp, o_who_d, o_data, o_err, o_other, exs[i]);
            end
        end
    endtask

    task automatic test_store();
        run(0, 1, 1, 3'd0, 32'h301, 32'h1234_5678, -10);
        checks++;
        if ({o_en, o_en_cyc, o_we, o_be, o_wd, o_addr} !== {32'd1, 32'd1, 1'b1, 4'b0010, 32'h7878_7878, 32'h300}) begin
            errors++; $display("FAIL store_sb_issue: en=%0d cyc=%0d we=%0b be=%b wd=%h addr=%h, expected 1 1 1 0010 78787878 300",
                               o_en, o_en_cyc, o_we, o_be, o_wd, o_addr);
        end
        checks++;
        if ({o_resp, o_who_d, o_data, o_err} !== {32'd2, 32'd1, 32'd0, 1'b0}) begin
            errors++; $display("FAIL store_sb_resp: cyc=%0d who_d=%0d data=%h err=%0b, expected 2 1 0 0", o_resp, o_who_d, o_data, o_err);
        end
    endtask

    task automatic test_errors();
        bit          dats [3] = '{1, 0, 1};
        bit          wes  [3] = '{1, 0, 0};
        logic [2:0]  f3s  [3] = '{3'd2, 3'd0, 3'd3};
        logic [31:0] as   [3] = '{32'h302, 32'h102, 32'h200};
        for (int i = 0; i < 3; i++) begin
            run(0, dats[i], wes[i], f3s[i], as[i], 32'hFFFF_FFFF, -10);
            checks++;
            if ({o_resp, o_en, o_who_d, o_err, o_data, o_rdy} !== {32'd1, 32'd0, 32'(dats[i]), 1'b1, 32'd0, 32'd1}) begin
                errors++; $display("FAIL error_%0d: cyc=%0d en=%0d who_d=%0d err=%0b data=%h rdy=%0d, expected 1 0 %0d 1 0 1",
                                   i, o_resp, o_en, o_who_d, o_err, o_data, o_rdy, dats[i]);
            end
        end
    endtask

    task automatic test_arbitration();
        int n = 0, en_acc = 0;
        reset_dut();
        @(posedge clk); #1;
        if_req_valid = 1; if_addr = 32'h100;
        d_req_valid = 1; d_we = 0; d_funct3 = 3'd2; d_addr = 32'h200;
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(negedge clk);
            if (m_en[0]) en_acc++;
            if (if_rv[0] || d_rv[0]) begin
                checks++;
                if ({if_rv[0], d_rv[0]} !== (n == 1 ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL arb_order_%0d: if/d resp %b%b expected %s", n, if_rv[0], d_rv[0], n == 1 ? "data" : "fetch");
                end
                checks++;
                if ((d_rv[0] ? d_rd[0] : if_rd[0]) !== (n == 1 ? mem[10'h080] : mem[10'h040])) begin
                    errors++; $display("FAIL arb_data_%0d: got %h expected %h", n, d_rv[0] ? d_rd[0] : if_rd[0],
                                       n == 1 ? mem[10'h080] : mem[10'h040]);
                end
                checks++;
                if (en_acc !== 1) begin
                    errors++; $display("FAIL arb_mem_en_%0d: got %0d strobes expected 1", n, en_acc);
                end
                en_acc = 0;
                n++;
            end
        end
        if_req_valid = 0; d_req_valid = 0;
        checks++;
        if (n !== 3) begin
            errors++; $display("FAIL arb_timeout: got %0d responses expected 3", n);
        end
    endtask

    task automatic test_latency();
        reset_dut();
        g_lo = 2; g_hi = 4;
        run(1, 1, 0, 3'd2, 32'h200, 0, -10);
        g_lo = 1; g_hi = 0;
        checks++;
        if ({o_en, o_resp, o_data, o_err} !== {32'd1, 32'd6, 32'h80F0_7F81, 1'b0}) begin
            errors++; $display("FAIL lat4_load: en=%0d cyc=%0d data=%h err=%0b, expected 1 6 80f07f81 0", o_en, o_resp, o_data, o_err);
        end
        run(1, 1, 0, 3'd0, 32'h200, 0, 3);
        checks++;
        if ({o_resp, o_rdy_rst} !== {-32'sd1, 32'd1}) begin
            errors++; $display("FAIL lat4_reset_drop: resp_cyc=%0d rdy_after_reset=%0d, expected -1 1", o_resp, o_rdy_rst);
        end
        run(1, 0, 0, 3'd0, 32'h100, 0, -10);
        checks++;
        if ({o_resp, o_who_d, o_data} !== {32'd6, 32'd0, 32'h0050_0093}) begin
            errors++; $display("FAIL lat4_after_reset: cyc=%0d who_d=%0d data=%h, expected 6 0 00500093", o_resp, o_who_d, o_data);
        end
    endtask

    task automatic test_random();
        bit dat, we, err;
        logic [2:0]  f3;
        logic [31:0] a, wd, ewd, edata;
        logic [3:0]  ebe;
        int eresp;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int k = 0; k < 2; k++) begin
            reset_dut();
            for (int t = 0; t < 40; t++) begin
                dat = 1'($urandom); we = dat && 1'($urandom); f3 = 3'($urandom_range(0, 7));
                a = $urandom; wd = $urandom;
                if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
                err   = err_model(dat, we, f3, a);
                eresp = err ? 1 : we ? 2 : 2 + (k == 1 ? 4 : 1);
                edata = (err || we) ? 0 : dat ? ld_model(mem[a[11:2]], f3, a) : mem[a[11:2]];
                ebe   = !we ? 4'hF : f3 == 3'd0 ? 4'(1 << a[1:0]) : f3 == 3'd1 ? 4'(3 << (a[1] ? 2 : 0)) : 4'hF;
                ewd   = f3 == 3'd0 ? wd[7:0] * 32'h0101_0101 : f3 == 3'd1 ? wd[15:0] * 32'h0001_0001 : wd;
                run(k, dat, we, f3, a, wd, -10);
                checks++;
                if ({o_resp, o_who_d, o_err, o_data, o_other, o_en, o_rdy} !==
                    {eresp, 32'(dat), err, edata, 32'd0, err ? 32'd0 : 32'd1, 32'd1}) begin
                    errors++; $display("FAIL rand_k%0d_%0d resp: cyc=%0d who_d=%0d err=%0b data=%h other=%0d en=%0d rdy=%0d, expected %0d %0d %0b %h 0 %0d 1",
                                       k, t, o_resp, o_who_d, o_err, o_data, o_other, o_en, o_rdy, eresp, dat, err, edata, !err);
                end
                if (!err) begin
                    checks++;
                    if ({o_addr, o_be, o_we} !== {a[31:2], 2'b00, ebe, we} || (we && o_wd !== ewd)) begin
                        errors++; $display("FAIL rand_k%0d_%0d mem: addr=%h be=%b we=%0b wd=%h, expected %h %b %0b %h",
                                           k, t, o_addr, o_be, o_we, o_wd, {a[31:2], 2'b00}, ebe, we, ewd);
                    end
                    if (we) for (int b = 0; b < 4; b++) if (ebe[b]) mem[a[11:2]][8*b +: 8] = ewd[8*b +: 8];
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 0;
        mem[10'h040] = 32'h0050_0093;
        mem[10'h080] = 32'h80F0_7F81;
        test_reset();
        test_fetch();
        test_loads();
        test_store();
        test_errors();
        test_arbitration();
        test_latency();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
